// File: rtl/hazard_tracker.sv
// hazard_tracker
//   Tracks the register specifiers of the instructions in X, M and W for the
//   bypass unit. Detects the load-use hazard between the load in X and the
//   instruction in D, and produces the PC/D stall controls.
//
// Ports
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   ID_instr         : instruction in D (32 bits)
//   ID_valid         : D holds a real instruction
//   branch_taken     : instruction in X redirects the PC this cycle
//   mem_busy         : data memory not ready, whole pipeline freezes
//   IX_RS1/RS2/RD    : specifiers of the instruction in X
//   IM_RS2/IM_RD     : specifiers of the instruction in M
//   IW_RD            : destination of the instruction in W
//   IX_is_load       : X holds a load
//   stall_f/stall_d  : hold PC / hold the D register
//   stall_count      : saturating count of load-use stall cycles
module hazard_tracker #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ID_instr,
  input  logic                   ID_valid,
  input  logic                   branch_taken,
  input  logic                   mem_busy,
  output logic [4:0]             IX_RS1,
  output logic [4:0]             IX_RS2,
  output logic [4:0]             IX_RD,
  output logic [4:0]             IM_RS2,
  output logic [4:0]             IM_RD,
  output logic [4:0]             IW_RD,
  output logic                   IX_is_load,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  // funct3/funct7 play no part in specifier tracking.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{ID_instr[31:25], ID_instr[14:12]};

  logic       rs1_used, rs2_used, rd_used, dec_ld;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       hz;

  logic [4:0] rs1_p0_q, rs1_p0_d;
  logic [4:0] rs2_p0_q, rs2_p0_d;
  logic [4:0] rd_p0_q,  rd_p0_d;
  logic       ld_p0_q,  ld_p0_d;
  logic [4:0] rs2_p1_q, rs2_p1_d;
  logic [4:0] rd_p1_q,  rd_p1_d;
  logic [4:0] rd_p2_q,  rd_p2_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  // D: decode which fields the instruction actually uses.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_used  = 1'b0;
    dec_ld   = 1'b0;
    if (ID_valid) begin
      unique case (ID_instr[6:0])
        OP_R:             begin rs1_used = 1'b1; rs2_used = 1'b1; rd_used = 1'b1; end
        OP_IALU, OP_JALR: begin rs1_used = 1'b1; rd_used = 1'b1; end
        OP_LOAD:          begin rs1_used = 1'b1; rd_used = 1'b1; dec_ld = 1'b1; end
        OP_STORE, OP_BR:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
        OP_LUI, OP_AUIPC, OP_JAL: rd_used = 1'b1;
        default: ;
      endcase
    end
    dec_rs1 = rs1_used ? ID_instr[19:15] : 5'd0;
    dec_rs2 = rs2_used ? ID_instr[24:20] : 5'd0;
    dec_rd  = rd_used  ? ID_instr[11:7]  : 5'd0;
  end

  // A load writing x0 produces nothing to wait for.
  assign hz = ld_p0_q & (rd_p0_q != 5'd0) & ID_valid &
              (((dec_rs1 == rd_p0_q) & rs1_used) | ((dec_rs2 == rd_p0_q) & rs2_used));

  // A taken branch discards the D instruction, so its hazard is moot.
  assign stall_f = (hz & ~branch_taken) | mem_busy;
  assign stall_d = stall_f;

  always_comb begin
    rs1_p0_d = rs1_p0_q;
    rs2_p0_d = rs2_p0_q;
    rd_p0_d  = rd_p0_q;
    ld_p0_d  = ld_p0_q;
    rs2_p1_d = rs2_p1_q;
    rd_p1_d  = rd_p1_q;
    rd_p2_d  = rd_p2_q;
    cnt_d    = cnt_q;
    if (!mem_busy) begin
      rd_p2_d  = rd_p1_q;
      rs2_p1_d = rs2_p0_q;
      rd_p1_d  = rd_p0_q;
      if (hz | branch_taken) begin
        rs1_p0_d = 5'd0;
        rs2_p0_d = 5'd0;
        rd_p0_d  = 5'd0;
        ld_p0_d  = 1'b0;
      end else begin
        rs1_p0_d = dec_rs1;
        rs2_p0_d = dec_rs2;
        rd_p0_d  = dec_rd;
        ld_p0_d  = dec_ld;
      end
      if (hz && !branch_taken && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // D->X, X->M, M->W stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_p0_q <= 5'd0;
      rs2_p0_q <= 5'd0;
      rd_p0_q  <= 5'd0;
      ld_p0_q  <= 1'b0;
      rs2_p1_q <= 5'd0;
      rd_p1_q  <= 5'd0;
      rd_p2_q  <= 5'd0;
      cnt_q    <= '0;
    end else begin
      rs1_p0_q <= rs1_p0_d;
      rs2_p0_q <= rs2_p0_d;
      rd_p0_q  <= rd_p0_d;
      ld_p0_q  <= ld_p0_d;
      rs2_p1_q <= rs2_p1_d;
      rd_p1_q  <= rd_p1_d;
      rd_p2_q  <= rd_p2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign IX_RS1      = rs1_p0_q;
  assign IX_RS2      = rs2_p0_q;
  assign IX_RD       = rd_p0_q;
  assign IX_is_load  = ld_p0_q;
  assign IM_RS2      = rs2_p1_q;
  assign IM_RD       = rd_p1_q;
  assign IW_RD       = rd_p2_q;
  assign stall_count = cnt_q;

endmodule
